hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding control for the 5-stage MIPS pipeline. Sits directly downstream of the per-stage A1/A2/A3/Tnew pipeline registers.
- Compares the D-stage source registers and their Tuse against the in-flight destinations and Tnew values. Produces the pipeline stall and all forwarding mux selects.
- Owns the HI/LO multiply/divide busy counter, so that MD-class instructions are held in D while the MD unit is running.

Parameters:
- MULT_CYCLES, 5: busy cycles loaded by mult/multu.
- DIV_CYCLES, 10: busy cycles loaded by div/divu.
- CNT_W, 4: width of the busy counter. Must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; the block resets when reset==0 at a clk rising edge
- D_A1  in  5  rs of the instruction in D
- D_A2  in  5  rt of the instruction in D
- D_Tuse1  in  2  cycles until D_A1 is needed; 3 = not used
- D_Tuse2  in  2  same for D_A2
- D_isMD  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- E_mdStart  in  1  mult/div is in E this cycle
- E_mdIsDiv  in  1  qualifies E_mdStart: 1 = div, 0 = mult
- DEA1  in  5  rs of the D/E register
- DEA2  in  5  rt of the D/E register
- DEA3  in  5  destination of the D/E register
- DETnew  in  2  Tnew of the D/E register
- EMA2  in  5  rt of the E/M register
- EMA3  in  5  destination of the E/M register
- EMTnew  in  2  Tnew of the E/M register
- MWA3  in  5  destination of the M/W register
- MWTnew  in  2  Tnew of the M/W register
- ExcClr  in  1  exception flush
- stall  out  1  freeze PC and F/D; bubble into D/E
- FwdD1  out  2  D-stage rs mux: 0 = GRF, 1 = E, 2 = M, 3 = W
- FwdD2  out  2  same for rt
- FwdE1  out  2  E-stage rs mux: 0 = D/E value, 2 = M, 3 = W
- FwdE2  out  2  same for rt
- FwdM2  out  2  M-stage rt (store data) mux: 0 = E/M value, 3 = W
- md_busy  out  1  busy counter is nonzero

Behaviour:
- Busy counter md_cnt [CNT_W-1:0] is the only architectural state besides the optional counter.
- Reset (reset==0 at posedge): md_cnt=0. All outputs are combinational from state and inputs, so after reset with all inputs 0: stall=0, all Fwd*=0, md_busy=0.
- md_cnt update per posedge, in priority order:
  - reset: load 0.
  - E_mdStart && md_cnt==0: load DIV_CYCLES if E_mdIsDiv, else MULT_CYCLES.
  - md_cnt!=0: decrement by 1.
  - otherwise: hold.
- E_mdStart while md_cnt!=0 is illegal (stall prevents it). The counter ignores it and keeps counting down; it does not reload.
- ExcClr does not affect md_cnt. A started MD operation always completes.
- md_busy = (md_cnt!=0).
- A "match" requires the addresses to be equal and the destination to be nonzero. Register 0 never matches.
- Data stall for rs: (match(D_A1,DEA3) && D_Tuse1<DETnew) || (match(D_A1,EMA3) && D_Tuse1<EMTnew). Same for rt using D_A2/D_Tuse2.
- The M/W stage never causes a stall.
- MD stall: D_isMD && (E_mdStart || md_busy).
- stall = rs data stall | rt data stall | MD stall. stall is purely combinational; no cycle of latency.
- Forwarding only selects a stage whose Tnew==0 and whose address matches. When several stages qualify, the nearest stage wins: E over M over W.
  - FwdD1/FwdD2 use the D/E, E/M and M/W stages.
  - FwdE1/FwdE2 use DEA1/DEA2 against E/M, then M/W.
  - FwdM2 uses EMA2 against M/W.
- A matching stage with Tnew!=0 blocks farther stages. The select falls to 0 (GRF / own value); the stall covers this case.
- Forwarding outputs are independent of stall and ExcClr.
- md_cnt wraps only through the load path; a decrement never goes below 0.

Optional Feature:
- Macro: HAZ_STATS_EN.
- When defined, add three outputs:
  - stall_cnt, 32-bit: increments on every posedge with stall==1. Reset 0; wraps from 0xFFFFFFFF to 0.
  - md_stall_cnt, 32-bit: increments on cycles with MD stall only. Reset 0; wraps from 0xFFFFFFFF to 0.
  - stats_clr, 1-bit input: when 1, clears both counters to 0 on that posedge. stats_clr has priority over increment.
- When undefined, these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with E_mdStart=1 -> md_cnt=0, md_busy=0, stall=0, all Fwd*=0.
- Load-use: D_A1=8, D_Tuse1=0, DEA3=8, DETnew=1 -> stall=1. Next case DEA3=0 with D_A1=0 -> stall=0, FwdD1=0.
- Forward priority: D_A2=9, DEA3=9/DETnew=0, EMA3=9/EMTnew=0, MWA3=9 -> FwdD2=1. Then set DEA3=5 -> FwdD2=2. Then set EMA3=5 -> FwdD2=3.
- Mult: pulse E_mdStart=1, E_mdIsDiv=0 with D_isMD=1.
  - Start cycle: stall=1.
  - md_busy=1 for exactly 5 cycles after the start edge.
  - stall drops in the cycle when md_cnt reaches 0.
- Div with ExcClr: pulse ExcClr=1 in the 3rd busy cycle of a div -> md_busy stays 1 for the full 10 cycles.
- HAZ_STATS_EN:
  - 7 stall cycles -> stall_cnt=7.
  - stats_clr asserted on the same posedge as a stall -> stall_cnt=0.
  - Preload 0xFFFFFFFF, then 1 stall -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding control for the 5-stage MIPS pipeline, plus MD busy counter.
// Ports: clk, reset (sync, active-low); D-stage sources/Tuse and D/E, E/M, M/W
// A1/A2/A3/Tnew in; stall, FwdD1/FwdD2/FwdE1/FwdE2/FwdM2, md_busy out.
// Optional stats (macro HAZ_STATS_EN): stats_clr in, stall_cnt/md_stall_cnt out.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_A1,
    input  logic [4:0] D_A2,
    input  logic [1:0] D_Tuse1,
    input  logic [1:0] D_Tuse2,
    input  logic       D_isMD,
    input  logic       E_mdStart,
    input  logic       E_mdIsDiv,
    input  logic [4:0] DEA1,
    input  logic [4:0] DEA2,
    input  logic [4:0] DEA3,
    input  logic [1:0] DETnew,
    input  logic [4:0] EMA2,
    input  logic [4:0] EMA3,
    input  logic [1:0] EMTnew,
    input  logic [4:0] MWA3,
    input  logic [1:0] MWTnew,
    input  logic       ExcClr,
    output logic       stall,
    output logic [1:0] FwdD1,
    output logic [1:0] FwdD2,
    output logic [1:0] FwdE1,
    output logic [1:0] FwdE2,
    output logic [1:0] FwdM2,
    output logic       md_busy
`ifdef HAZ_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] md_cnt;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;

    // An exception flush never cancels a running mult/div.
    logic unused_exc;
    assign unused_exc = ExcClr;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] src,
                                 input logic [4:0] dst);
        return (src == dst) && (dst != 5'd0);
    endfunction

    // Nearest matching stage wins; a match that is not ready yet
    // blocks farther stages and leaves the select at 0.
    function automatic logic [1:0] pick(
        input logic e_hit, input logic e_rdy,
        input logic m_hit, input logic m_rdy,
        input logic w_hit, input logic w_rdy
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (e_hit) begin
            if (e_rdy) sel = 2'd1;
        end else if (m_hit) begin
            if (m_rdy) sel = 2'd2;
        end else if (w_hit) begin
            if (w_rdy) sel = 2'd3;
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt <= '0;
        end else begin
            unique case (1'b1)
                (E_mdStart && md_cnt == '0):
                    md_cnt <= E_mdIsDiv ? DIV_LD : MULT_LD;
                (md_cnt != '0):
                    md_cnt <= md_cnt - 1'b1;
                default:
                    md_cnt <= md_cnt;
            endcase
        end
    end

    assign md_busy = (md_cnt != '0);

    always_comb begin
        stall_rs = (hit(D_A1, DEA3) && (D_Tuse1 < DETnew))
                 || (hit(D_A1, EMA3) && (D_Tuse1 < EMTnew));
        stall_rt = (hit(D_A2, DEA3) && (D_Tuse2 < DETnew))
                 || (hit(D_A2, EMA3) && (D_Tuse2 < EMTnew));
        stall_md = D_isMD && (E_mdStart || md_busy);
        stall    = stall_rs || stall_rt || stall_md;
    end

    always_comb begin
        FwdD1 = pick(hit(D_A1, DEA3), DETnew == 2'd0,
                     hit(D_A1, EMA3), EMTnew == 2'd0,
                     hit(D_A1, MWA3), MWTnew == 2'd0);
        FwdD2 = pick(hit(D_A2, DEA3), DETnew == 2'd0,
                     hit(D_A2, EMA3), EMTnew == 2'd0,
                     hit(D_A2, MWA3), MWTnew == 2'd0);
        FwdE1 = pick(1'b0, 1'b0,
                     hit(DEA1, EMA3), EMTnew == 2'd0,
                     hit(DEA1, MWA3), MWTnew == 2'd0);
        FwdE2 = pick(1'b0, 1'b0,
                     hit(DEA2, EMA3), EMTnew == 2'd0,
                     hit(DEA2, MWA3), MWTnew == 2'd0);
        FwdM2 = pick(1'b0, 1'b0,
                     1'b0, 1'b0,
                     hit(EMA2, MWA3), MWTnew == 2'd0);
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset || stats_clr) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall)    stall_cnt    <= stall_cnt + 32'd1;
            if (stall_md) md_stall_cnt <= md_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, stalls, forwarding priority,
// mult/div busy timing, and the optional stats counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_A1, D_A2, DEA1, DEA2, DEA3, EMA2, EMA3, MWA3;
    logic [1:0] D_Tuse1, D_Tuse2, DETnew, EMTnew, MWTnew;
    logic       D_isMD, E_mdStart, E_mdIsDiv, ExcClr;
    logic       stall, md_busy;
    logic [1:0] FwdD1, FwdD2, FwdE1, FwdE2, FwdM2;
`ifdef HAZ_STATS_EN
    logic        stats_clr;
    logic [31:0] stall_cnt, md_stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .D_A1(D_A1), .D_A2(D_A2),
        .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
        .D_isMD(D_isMD), .E_mdStart(E_mdStart),
        .E_mdIsDiv(E_mdIsDiv),
        .DEA1(DEA1), .DEA2(DEA2), .DEA3(DEA3),
        .DETnew(DETnew), .EMA2(EMA2), .EMA3(EMA3),
        .EMTnew(EMTnew), .MWA3(MWA3), .MWTnew(MWTnew),
        .ExcClr(ExcClr), .stall(stall),
        .FwdD1(FwdD1), .FwdD2(FwdD2), .FwdE1(FwdE1),
        .FwdE2(FwdE2), .FwdM2(FwdM2), .md_busy(md_busy)
`ifdef HAZ_STATS_EN
        ,
        .stats_clr(stats_clr), .stall_cnt(stall_cnt),
        .md_stall_cnt(md_stall_cnt)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        D_A1 = 0; D_A2 = 0; D_Tuse1 = 3; D_Tuse2 = 3;
        D_isMD = 0; E_mdStart = 0; E_mdIsDiv = 0;
        DEA1 = 0; DEA2 = 0; DEA3 = 0; DETnew = 0;
        EMA2 = 0; EMA3 = 0; EMTnew = 0;
        MWA3 = 0; MWTnew = 0; ExcClr = 0;
`ifdef HAZ_STATS_EN
        stats_clr = 0;
`endif
    endtask

    initial begin
        idle();
        D_Tuse1 = 0; D_Tuse2 = 0;
        reset = 0;
        E_mdStart = 1;
        repeat (2) @(negedge clk);
        E_mdStart = 0;
        #1;
        chk("rst_busy", md_busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fwd", {FwdD1, FwdD2, FwdE1, FwdE2, FwdM2}, 0);
        @(negedge clk);
        reset = 1;
        idle();

        // load-use on rs
        D_A1 = 8; D_Tuse1 = 0; DEA3 = 8; DETnew = 1; #1;
        chk("lu_stall", stall, 1);
        chk("lu_fwd", FwdD1, 0);
        D_A1 = 0; DEA3 = 0; #1;
        chk("r0_stall", stall, 0);
        chk("r0_fwd", FwdD1, 0);

        // D-stage forwarding priority on rt
        idle();
        D_A2 = 9; DEA3 = 9; EMA3 = 9; MWA3 = 9; #1;
        chk("pri_e", FwdD2, 1);
        DEA3 = 5; #1;
        chk("pri_m", FwdD2, 2);
        EMA3 = 5; #1;
        chk("pri_w", FwdD2, 3);

        // not-ready nearer stage blocks farther ones
        idle();
        D_A2 = 9; DEA3 = 9; DETnew = 2; EMA3 = 9; D_Tuse2 = 1; #1;
        chk("blk_fwd", FwdD2, 0);
        chk("blk_stall", stall, 1);
        D_Tuse2 = 2; #1;
        chk("blk_nostall", stall, 0);

        // E/M stage stall on rt, M/W never stalls
        idle();
        D_A2 = 7; EMA3 = 7; EMTnew = 1; D_Tuse2 = 0; #1;
        chk("em_stall", stall, 1);
        EMA3 = 0; MWA3 = 7; MWTnew = 2; #1;
        chk("mw_nostall", stall, 0);
        chk("mw_notrdy", FwdD2, 0);

        // E and M stage forwarding
        idle();
        DEA1 = 4; EMA3 = 4; MWA3 = 4; #1;
        chk("fe1_m", FwdE1, 2);
        EMA3 = 6; #1;
        chk("fe1_w", FwdE1, 3);
        chk("fe2_r0", FwdE2, 0);
        EMA2 = 11; MWA3 = 11; #1;
        chk("fm2_w", FwdM2, 3);
        MWTnew = 1; #1;
        chk("fm2_notrdy", FwdM2, 0);

        // mult: 5 busy cycles after the start edge
        @(negedge clk);
        idle();
        D_isMD = 1; E_mdStart = 1; #1;
        chk("mul_start_stall", stall, 1);
        @(negedge clk);
        E_mdStart = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mul_busy%0d", i), md_busy, 1);
            chk($sformatf("mul_stall%0d", i), stall, 1);
            @(negedge clk);
        end
        #1;
        chk("mul_done", md_busy, 0);
        chk("mul_stall_end", stall, 0);

        // div: flush and a stray start do not disturb the count
        @(negedge clk);
        idle();
        D_isMD = 1; E_mdStart = 1; E_mdIsDiv = 1;
        @(negedge clk);
        E_mdStart = 0; E_mdIsDiv = 0;
        for (int i = 0; i < 10; i++) begin
            ExcClr = (i == 2);
            E_mdStart = (i == 4);
            #1;
            chk($sformatf("div_busy%0d", i), md_busy, 1);
            @(negedge clk);
        end
        ExcClr = 0; E_mdStart = 0; #1;
        chk("div_done", md_busy, 0);
        chk("div_stall_end", stall, 0);

`ifdef HAZ_STATS_EN
        @(negedge clk);
        idle();
        stats_clr = 1;
        @(negedge clk);
        stats_clr = 0;
        D_A1 = 8; D_Tuse1 = 0; DEA3 = 8; DETnew = 1;
        repeat (7) @(negedge clk);
        #1;
        chk("st_cnt7", stall_cnt, 7);
        chk("st_md0", md_stall_cnt, 0);
        stats_clr = 1;
        @(negedge clk);
        stats_clr = 0; #1;
        chk("st_clr", stall_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
